floating_point_div: RTL and testbench

Sequential IEEE-754-style floating-point divider: computes dataAIn / dataBIn with one restoring-division quotient bit per clock. It is the inverse-operation companion to the floating-point multiplier in the accelerator datapath and shares its number format, special-value encodings and truncation rounding. A valid/ready input handshake holds off new operands while a division is in flight. A single-cycle validOut pulse marks each result.

---
 rtl/floating_point_div.sv | 130 +++++++++++++
 tb/tb_floating_point_div.sv | 112 +++++++++++
 2 files changed

// File: rtl/floating_point_div.sv
// floating_point_div: sequential restoring divider, one quotient bit per clock, truncating.
module floating_point_div #(
  parameter int FRAC_WIDTH = 23,
  parameter int EXP_WIDTH = 8,
  localparam int DATA_WIDTH = FRAC_WIDTH + EXP_WIDTH + 1
) (
  input  logic                  clkIn,
  input  logic                  rstnIn,
  input  logic [DATA_WIDTH-1:0] dataAIn,
  input  logic [DATA_WIDTH-1:0] dataBIn,
  input  logic                  validIn,
  output logic                  readyOut,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut
);
  localparam int BIAS = 2**(EXP_WIDTH-1) - 1;
  localparam int CW = $clog2(FRAC_WIDTH + 2);
  localparam int XW = EXP_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;

  state_t                 state_q;
  logic                   sign_q;
  logic signed [XW-1:0]   exp_q;
  logic [FRAC_WIDTH+1:0]  rem_q;
  logic [FRAC_WIDTH:0]    div_q;
  logic [FRAC_WIDTH+1:0]  quo_q;
  logic [CW-1:0]          cnt_q;
  logic                   special_q;
  logic [DATA_WIDTH-1:0]  res_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   valid_q;

  logic                   a_sign, b_sign, sign_d;
  logic [EXP_WIDTH-1:0]   a_exp, b_exp;
  logic [FRAC_WIDTH-1:0]  a_frac, b_frac;
  logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                   is_nan, is_inf, is_zero, special_d;
  logic [DATA_WIDTH-1:0]  spec_res, norm_res;
  logic signed [XW-1:0]   exp_d, exp_n;
  logic [FRAC_WIDTH-1:0]  frac_n;
  logic                   ovf, unf, ge, last;
  logic [FRAC_WIDTH+1:0]  sub, rem_d, quo_d;

  assign {a_sign, a_exp, a_frac} = dataAIn;
  assign {b_sign, b_exp, b_frac} = dataBIn;
  assign readyOut = (state_q == IDLE);
  assign dataOut  = data_q;
  assign validOut = valid_q;

  // Exponent-zero operands count as zero, so subnormals flush.
  always_comb begin
    a_nan     = (&a_exp) && (|a_frac);
    b_nan     = (&b_exp) && (|b_frac);
    a_inf     = (&a_exp) && !(|a_frac);
    b_inf     = (&b_exp) && !(|b_frac);
    a_zero    = (a_exp == '0);
    b_zero    = (b_exp == '0);
    sign_d    = a_sign ^ b_sign;
    is_nan    = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
    is_inf    = a_inf || b_zero;
    is_zero   = a_zero || b_inf;
    special_d = is_nan || is_inf || is_zero;
    spec_res  = is_nan ? {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}} :
                is_inf ? {sign_d, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}} :
                         {sign_d, {(DATA_WIDTH-1){1'b0}}};
    exp_d     = {2'b00, a_exp} - {2'b00, b_exp} + XW'(BIAS);
  end

  always_comb begin
    ge    = rem_q >= {1'b0, div_q};
    sub   = ge ? rem_q - {1'b0, div_q} : rem_q;
    rem_d = {sub[FRAC_WIDTH:0], 1'b0};
    quo_d = {quo_q[FRAC_WIDTH:0], ge};
    last  = (cnt_q == CW'(FRAC_WIDTH + 1));
  end

  // Quotient lies in [1,4) scaled by 2^FRAC_WIDTH; top bit picks the normalisation shift.
  always_comb begin
    exp_n    = quo_q[FRAC_WIDTH+1] ? exp_q : exp_q - XW'(1);
    frac_n   = quo_q[FRAC_WIDTH+1] ? quo_q[FRAC_WIDTH:1] : quo_q[FRAC_WIDTH-1:0];
    ovf      = !exp_n[XW-1] && (exp_n[XW-2:0] >= (XW-1)'(2**EXP_WIDTH - 1));
    unf      = exp_n[XW-1] || (exp_n == '0);
    norm_res = ovf ? {sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}} :
               unf ? {sign_q, {(DATA_WIDTH-1){1'b0}}} :
                     {sign_q, exp_n[EXP_WIDTH-1:0], frac_n};
  end

  always_ff @(posedge clkIn or negedge rstnIn) begin
    if (!rstnIn) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      special_q <= 1'b0;
      res_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= (state_q == OUT);
      case (state_q)
        IDLE: if (validIn) begin
          sign_q    <= sign_d;
          exp_q     <= exp_d;
          rem_q     <= {1'b0, 1'b1, a_frac};
          div_q     <= {1'b1, b_frac};
          quo_q     <= '0;
          cnt_q     <= '0;
          special_q <= special_d;
          res_q     <= spec_res;
          state_q   <= special_d ? OUT : DIV;
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) state_q <= OUT;
        end
        OUT: begin
          data_q  <= special_q ? res_q : norm_res;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_floating_point_div.sv
// tb_floating_point_div: directed vectors for the sequential divider with hand-computed results.
module tb_floating_point_div;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        vin = 1'b0;
  logic        rdy, vout;
  logic [31:0] dout;
  int          errors = 0, checks = 0;

  floating_point_div dut (
    .clkIn(clk), .rstnIn(rstn), .dataAIn(a), .dataBIn(b), .validIn(vin),
    .readyOut(rdy), .dataOut(dout), .validOut(vout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] expv, input int lat);
    int n;
    logic bad;
    @(negedge clk);
    a = x; b = y; vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    bad = rdy;
    n = 0;
    while (!vout && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (!vout && rdy) bad = 1'b1;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_data"}, dout, expv);
    chk({tag, "_busy"}, {31'd0, bad}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
  endtask

  initial begin
    int n, pulses;
    #1;
    chk("rst_data", dout, 32'h0);
    chk("rst_valid", {31'd0, vout}, 32'd0);
    chk("rst_ready", {31'd0, rdy}, 32'd1);
    @(negedge clk); rstn = 1'b1;

    run("div6_2",   32'h40C00000, 32'h40000000, 32'h40400000, 26);
    run("third",    32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26);
    run("neg4_2",   32'hC0800000, 32'h40000000, 32'hC0000000, 26);
    run("one_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1);
    run("zero_zero",32'h00000000, 32'h00000000, 32'h7FC00000, 1);
    run("inf_inf",  32'h7F800000, 32'h7F800000, 32'h7FC00000, 1);
    run("nan_one",  32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1);
    run("neg_inf",  32'hBF800000, 32'h7F800000, 32'h80000000, 1);
    run("ovf",      32'h7F000000, 32'h00800000, 32'h7F800000, 26);
    run("unf",      32'h00800000, 32'h40000000, 32'h00000000, 26);
    run("subnorm",  32'h00000001, 32'h3F800000, 32'h00000000, 1);

    // validIn held high with operands churning; only accept-edge values count.
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; vin = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!vout && n < 100) begin
      @(negedge clk); a = $urandom; b = $urandom;
      @(posedge clk); #1; n++;
    end
    chk("hs1_lat", n, 26);
    chk("hs1_data", dout, 32'h40400000);
    @(negedge clk); a = 32'hC0800000; b = 32'h40000000;
    @(posedge clk); #1;
    chk("hs2_accept", {31'd0, rdy}, 32'd0);
    n = 0;
    while (!vout && n < 100) begin
      @(negedge clk); a = $urandom; b = $urandom;
      @(posedge clk); #1; n++;
    end
    vin = 1'b0;
    chk("hs2_lat", n, 26);
    chk("hs2_data", dout, 32'hC0000000);

    // Reset dropped after DIV edge 10 of a fresh division.
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; vin = 1'b1;
    @(posedge clk); #1; vin = 1'b0;
    repeat (10) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_data", dout, 32'h0);
    chk("mid_rst_valid", {31'd0, vout}, 32'd0);
    chk("mid_rst_ready", {31'd0, rdy}, 32'd1);
    @(negedge clk); rstn = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (vout) pulses++;
    end
    chk("mid_rst_nopulse", pulses, 0);
    run("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 26);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
